// File: rtl/fixed_block_quantizer_if.sv
// Stream bundle for the block quantizer: input beats in, quantized beats
// plus the block max-abs out. The quantizer takes the slave side.
interface fixed_block_quantizer_if #(
  parameter int IN_WIDTH  = 16,
  parameter int IN_SIZE   = 4,
  parameter int OUT_WIDTH = 8
);
  logic [IN_SIZE-1:0][IN_WIDTH-1:0]  data_in;
  logic                              data_in_valid;
  logic                              data_in_ready;
  logic [IN_SIZE-1:0][OUT_WIDTH-1:0] data_out;
  logic [IN_WIDTH-1:0]               data_out_max_num;
  logic                              data_out_valid;
  logic                              data_out_ready;

  modport master (
    output data_in, data_in_valid, data_out_ready,
    input  data_in_ready, data_out, data_out_max_num, data_out_valid
  );

  modport slave (
    input  data_in, data_in_valid, data_out_ready,
    output data_in_ready, data_out, data_out_max_num, data_out_valid
  );
endinterface

// File: rtl/fixed_block_quantizer.sv
// Block-wise symmetric quantizer: buffer one block, find its max |x|,
// compute floor(Q*2^RECIP_WIDTH / max) with a bit-serial divider, then
// stream the block back out scaled, rounded and saturated to [-Q, Q].
//
// state   | meaning
// S_FILL  | accepting input beats, tracking running max |x|
// S_DIV   | one load cycle, then DIV_CYCLES restoring-division steps
// S_DRAIN | emitting quantized beats with the block max alongside
module fixed_block_quantizer #(
  parameter int IN_WIDTH    = 16,
  parameter int IN_SIZE     = 4,
  parameter int IN_DEPTH    = 2,
  parameter int OUT_WIDTH   = 8,
  parameter int RECIP_WIDTH = 16,
  parameter int DIV_CYCLES  = OUT_WIDTH - 1 + RECIP_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  fixed_block_quantizer_if.slave bus
);
  localparam int PTR_W = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam int CNT_W = $clog2(DIV_CYCLES + 2);
  localparam int MUL_W = IN_WIDTH + OUT_WIDTH - 1 + RECIP_WIDTH;
  localparam int Q     = 2 ** (OUT_WIDTH - 1) - 1;

  localparam logic [DIV_CYCLES-1:0]   NUMER     = DIV_CYCLES'(Q) << RECIP_WIDTH;
  localparam logic [IN_WIDTH-1:0]     MOST_NEG  = {1'b1, {(IN_WIDTH-1){1'b0}}};
  localparam logic [IN_WIDTH-1:0]     MOST_POS  = {1'b0, {(IN_WIDTH-1){1'b1}}};
  localparam logic signed [MUL_W-1:0] ROUND     = MUL_W'(1) << (RECIP_WIDTH - 1);
  localparam logic signed [MUL_W-1:0] Q_POS     = MUL_W'(Q);
  localparam logic signed [MUL_W-1:0] Q_NEG     = -Q_POS;
  localparam logic [CNT_W-1:0]        CNT_LOAD  = CNT_W'(DIV_CYCLES + 1);

  typedef enum logic [1:0] {S_FILL, S_DIV, S_DRAIN} state_t;

  state_t r_state, w_state_nxt;

  logic [IN_SIZE-1:0][IN_WIDTH-1:0] r_buf [IN_DEPTH];
  logic [PTR_W-1:0]                 r_wr_ptr, r_rd_ptr;
  logic [IN_WIDTH-1:0]              r_max_abs;
  logic [CNT_W-1:0]                 r_div_cnt;
  logic [IN_WIDTH-1:0]              r_rem;
  logic [DIV_CYCLES-1:0]            r_num;
  logic [DIV_CYCLES-1:0]            r_quo;

  logic                              w_in_ready, w_out_valid;
  logic                              w_in_fire, w_out_fire;
  logic                              w_wr_last, w_rd_last, w_div_done;
  logic [IN_WIDTH-1:0]               w_abs, w_blk_max;
  logic [IN_WIDTH:0]                 w_trial;
  logic                              w_ge;
  logic signed [MUL_W-1:0]           w_acc;
  logic [IN_SIZE-1:0][OUT_WIDTH-1:0] w_data_out;

  // Handshakes are held off while reset is asserted so outputs read idle.
  assign w_in_ready  = rst && (r_state == S_FILL);
  assign w_out_valid = rst && (r_state == S_DRAIN);
  assign w_in_fire   = w_in_ready && bus.data_in_valid;
  assign w_out_fire  = w_out_valid && bus.data_out_ready;
  assign w_wr_last   = (r_wr_ptr == PTR_W'(IN_DEPTH - 1));
  assign w_rd_last   = (r_rd_ptr == PTR_W'(IN_DEPTH - 1));
  assign w_div_done  = (r_div_cnt == CNT_W'(1));

  // A zero max leaves the quotient at zero instead of dividing by zero.
  assign w_trial = {r_rem, r_num[DIV_CYCLES-1]};
  assign w_ge    = (r_max_abs != '0) && (w_trial >= {1'b0, r_max_abs});

  // Running max of saturated |x| over the incoming beat.
  always_comb begin
    w_blk_max = r_max_abs;
    w_abs     = '0;
    for (int i = 0; i < IN_SIZE; i++) begin
      if (bus.data_in[i] == MOST_NEG)
        w_abs = MOST_POS;
      else if (bus.data_in[i][IN_WIDTH-1])
        w_abs = -bus.data_in[i];
      else
        w_abs = bus.data_in[i];
      if (w_abs > w_blk_max)
        w_blk_max = w_abs;
    end
  end

  // Scale, round half toward +inf, saturate; zero outside DRAIN.
  always_comb begin
    w_data_out = '0;
    w_acc      = '0;
    for (int i = 0; i < IN_SIZE; i++) begin
      w_acc = MUL_W'($signed(r_buf[r_rd_ptr][i])) * MUL_W'($signed({1'b0, r_quo}));
      w_acc = (w_acc + ROUND) >>> RECIP_WIDTH;
      if (w_acc > Q_POS)
        w_acc = Q_POS;
      else if (w_acc < Q_NEG)
        w_acc = Q_NEG;
      if (w_out_valid)
        w_data_out[i] = w_acc[OUT_WIDTH-1:0];
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FILL:  if (w_in_fire && w_wr_last)   w_state_nxt = S_DIV;
      S_DIV:   if (w_div_done)               w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_out_fire && w_rd_last)  w_state_nxt = S_FILL;
      default:                               w_state_nxt = S_FILL;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst)
      r_state <= S_FILL;
    else
      r_state <= w_state_nxt;
  end

  // Block buffer; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_in_fire)
      r_buf[r_wr_ptr] <= bus.data_in;
  end

  // Pointers, max tracking and the bit-serial divider.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_max_abs <= '0;
      r_div_cnt <= '0;
      r_rem     <= '0;
      r_num     <= '0;
      r_quo     <= '0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (w_in_fire) begin
            r_wr_ptr  <= r_wr_ptr + 1'b1;
            r_max_abs <= w_blk_max;
            if (w_wr_last)
              r_div_cnt <= CNT_LOAD;
          end
        end
        S_DIV: begin
          r_div_cnt <= r_div_cnt - 1'b1;
          if (r_div_cnt == CNT_LOAD) begin
            r_rem <= '0;
            r_num <= NUMER;
            r_quo <= '0;
          end else begin
            r_rem <= w_ge ? IN_WIDTH'(w_trial - {1'b0, r_max_abs}) : w_trial[IN_WIDTH-1:0];
            r_num <= r_num << 1;
            r_quo <= {r_quo[DIV_CYCLES-2:0], w_ge};
          end
        end
        S_DRAIN: begin
          if (w_out_fire) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_rd_last) begin
              r_wr_ptr  <= '0;
              r_rd_ptr  <= '0;
              r_max_abs <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.data_in_ready    = w_in_ready;
  assign bus.data_out_valid   = w_out_valid;
  assign bus.data_out         = w_data_out;
  assign bus.data_out_max_num = w_out_valid ? r_max_abs : '0;
endmodule

// File: tb/tb_fixed_block_quantizer.sv
// Directed bench for fixed_block_quantizer with hand-computed vectors.
module tb_fixed_block_quantizer;
  localparam int IN_WIDTH    = 16;
  localparam int IN_SIZE     = 4;
  localparam int IN_DEPTH    = 2;
  localparam int OUT_WIDTH   = 8;
  localparam int RECIP_WIDTH = 16;

  typedef int beat_t [4];

  logic clk = 1'b0;
  logic rst;
  int   n_err = 0;
  int   n_chk = 0;

  always #5 clk = ~clk;

  fixed_block_quantizer_if #(
    .IN_WIDTH(IN_WIDTH), .IN_SIZE(IN_SIZE), .OUT_WIDTH(OUT_WIDTH)
  ) u_if ();

  fixed_block_quantizer #(
    .IN_WIDTH(IN_WIDTH), .IN_SIZE(IN_SIZE), .IN_DEPTH(IN_DEPTH),
    .OUT_WIDTH(OUT_WIDTH), .RECIP_WIDTH(RECIP_WIDTH)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(u_if)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input beat_t b);
    int n;
    for (int i = 0; i < IN_SIZE; i++)
      u_if.data_in[i] = IN_WIDTH'(b[i]);
    u_if.data_in_valid = 1'b1;
    n = 0;
    while (!u_if.data_in_ready && n < 200) begin
      tick();
      n++;
    end
    chk("in_ready_wait", int'(u_if.data_in_ready), 1);
    tick();
    u_if.data_in_valid = 1'b0;
  endtask

  task automatic check_beat(input string tag, input beat_t e, input int emax);
    chk({tag, "_valid"}, int'(u_if.data_out_valid), 1);
    for (int i = 0; i < IN_SIZE; i++)
      chk($sformatf("%s_q%0d", tag, i), int'($signed(u_if.data_out[i])), e[i]);
    chk({tag, "_max"}, int'(u_if.data_out_max_num), emax);
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!u_if.data_out_valid && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic recv_beat(input string tag, input beat_t e, input int emax);
    int lat;
    wait_valid(lat);
    check_beat(tag, e, emax);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;

    rst                 = 1'b0;
    u_if.data_in        = '0;
    u_if.data_in_valid  = 1'b0;
    u_if.data_out_ready = 1'b1;
    repeat (3) tick();

    chk("rst_in_ready",  int'(u_if.data_in_ready), 0);
    chk("rst_out_valid", int'(u_if.data_out_valid), 0);
    chk("rst_max",       int'(u_if.data_out_max_num), 0);
    chk("rst_data",      int'(u_if.data_out), 0);
    rst = 1'b1;
    #1;
    chk("post_rst_in_ready", int'(u_if.data_in_ready), 1);

    // Basic block, latency and back-to-back drain.
    send_beat('{100, -50, 25, 0});
    send_beat('{200, -200, 10, 1});
    wait_valid(lat);
    chk("latency", lat, 25);
    check_beat("b1_0", '{63, -32, 16, 0}, 200);
    tick();
    check_beat("b1_1", '{127, -127, 6, 1}, 200);
    tick();
    chk("b1_end_valid", int'(u_if.data_out_valid), 0);
    chk("b1_end_in_ready", int'(u_if.data_in_ready), 1);

    // All-zero block.
    send_beat('{0, 0, 0, 0});
    send_beat('{0, 0, 0, 0});
    wait_valid(lat);
    chk("zero_latency", lat, 25);
    check_beat("z_0", '{0, 0, 0, 0}, 0);
    tick();
    check_beat("z_1", '{0, 0, 0, 0}, 0);
    tick();
    chk("z_end_valid", int'(u_if.data_out_valid), 0);

    // Full-scale values, including the saturating most-negative input.
    send_beat('{-32768, 32767, 1000, -1000});
    send_beat('{16384, -16384, 0, 0});
    recv_beat("fs_0", '{-127, 127, 4, -4}, 32767);
    recv_beat("fs_1", '{64, -63, 0, 0}, 32767);

    // Backpressure on the first output beat.
    u_if.data_out_ready = 1'b0;
    send_beat('{100, -50, 25, 0});
    send_beat('{200, -200, 10, 1});
    wait_valid(lat);
    check_beat("bp_first", '{63, -32, 16, 0}, 200);
    for (int k = 0; k < 5; k++) begin
      tick();
      check_beat($sformatf("bp_hold%0d", k), '{63, -32, 16, 0}, 200);
      chk($sformatf("bp_in_ready%0d", k), int'(u_if.data_in_ready), 0);
    end
    u_if.data_out_ready = 1'b1;
    #1;
    check_beat("bp_0", '{63, -32, 16, 0}, 200);
    tick();
    check_beat("bp_1", '{127, -127, 6, 1}, 200);
    tick();
    chk("bp_end_valid", int'(u_if.data_out_valid), 0);
    chk("bp_end_in_ready", int'(u_if.data_in_ready), 1);

    // Reset in the middle of the division discards the block.
    send_beat('{1000, -1000, 500, 3});
    send_beat('{7, 7, 7, 7});
    repeat (5) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", int'(u_if.data_out_valid), 0);
    chk("mid_rst_in_ready", int'(u_if.data_in_ready), 1);
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      if (u_if.data_out_valid) seen++;
      tick();
    end
    chk("mid_rst_no_partial", seen, 0);
    send_beat('{10, -5, 3, 2});
    send_beat('{1, 0, -10, 7});
    recv_beat("ar_0", '{127, -63, 38, 25}, 10);
    recv_beat("ar_1", '{13, 0, -127, 89}, 10);
    chk("ar_end_valid", int'(u_if.data_out_valid), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/fixed_block_quantizer.md
# fixed_block_quantizer

Block-wise symmetric quantizer. It collects one block of `IN_DEPTH` beats of fixed-point data and finds the block's maximum absolute value. It then streams the block back out as signed `OUT_WIDTH` integers, together with that maximum as `data_out_max_num`. It produces the `data_in_0_max_num` / `weight_max_num` streams consumed by the linear dequantization path, and sits between an activation (or weight) producer and that layer.

## Interface

Parameters:
- `IN_WIDTH`, 16, signed input element width.
- `IN_SIZE`, 4, elements per beat (parallelism).
- `IN_DEPTH`, 2, beats per quantization block; must be ≥1.
- `OUT_WIDTH`, 8, signed quantized element width; `Q = 2^(OUT_WIDTH-1)-1`.
- `RECIP_WIDTH`, 16, fractional bits of the reciprocal scale.
- `DIV_CYCLES`, `OUT_WIDTH-1+RECIP_WIDTH`, derived; number of divider iterations.

Ports:
- `clk`, in, 1, the single clock.
- `rst`, in, 1. Reset is synchronous and active-low, on the single clock `clk`.
- `data_in`, in, `IN_WIDTH` x `IN_SIZE`, input beat.
- `data_in_valid`, in, 1, input handshake.
- `data_in_ready`, out, 1, input handshake.
- `data_out`, out, `OUT_WIDTH` x `IN_SIZE`, quantized beat.
- `data_out_max_num`, out, `IN_WIDTH`, block max-abs; constant for the whole block.
- `data_out_valid`, out, 1, output handshake.
- `data_out_ready`, in, 1, output handshake.

## Operation

States and transitions:
- FILL: `data_in_ready`=1.
  - Each input handshake writes the beat to `buffer[wr_ptr]` and increments `wr_ptr`.
  - It also updates `max_abs = max(max_abs, |x|)` over all `IN_SIZE` elements.
  - `|x|` of `-2^(IN_WIDTH-1)` saturates to `2^(IN_WIDTH-1)-1`.
  - The handshake on beat `IN_DEPTH-1` moves to DIV.
- DIV: 1 load cycle, then `DIV_CYCLES` restoring-division iterations, one quotient bit per cycle.
  - Result: `recip = floor(Q·2^RECIP_WIDTH / max_abs)`.
  - If `max_abs==0`, then `recip=0`.
  - Then move to DRAIN.
- DRAIN: `data_out_valid`=1, `data_out_max_num`=`max_abs`.
  - Per element: `q = (x·recip + 2^(RECIP_WIDTH-1)) >>> RECIP_WIDTH`.
  - This is an arithmetic shift, i.e. round half toward +inf.
  - `q` then saturates to `[-Q, Q]`.
  - `data_out` is computed from `buffer[rd_ptr]`.
  - `rd_ptr` increments on each output handshake.
  - The handshake on beat `IN_DEPTH-1` moves to FILL and clears `max_abs`, `wr_ptr` and `rd_ptr`.

Rules:
- Single buffer; blocks do not overlap. `data_in_ready`=0 in DIV and DRAIN.
- `data_out` is forced to 0 whenever `data_out_valid`=0.
- Multiply width: `IN_WIDTH + OUT_WIDTH-1 + RECIP_WIDTH` signed; no intermediate truncation.

## Timing

- Reset (`rst`=0 at a clock edge):
  - Outputs: `data_in_ready`=0, `data_out_valid`=0, `data_out_max_num`=0, `data_out`=0.
  - Internal state: state=FILL, pointers, `max_abs`, `recip` all 0.
  - `data_in_ready`=1 in the first cycle after `rst` returns high.
- Reset mid-DIV or mid-DRAIN discards the block entirely. No partial block is emitted.
- Latency: with the last input handshake at edge T, `data_out_valid` first rises at cycle T+`DIV_CYCLES`+2 (25 cycles for defaults).
- Throughput in DRAIN is 1 beat/cycle when `data_out_ready`=1.
- Backpressure: while `data_out_valid`=1 and `data_out_ready`=0, `data_out` and `data_out_max_num` hold stable.
- After the last output handshake at edge T:
  - `data_out_valid`=0 and `data_in_ready`=1 from cycle T+1.
  - The minimum block period is `2·IN_DEPTH + DIV_CYCLES + 1` cycles.
- `data_in_valid` during DIV/DRAIN is ignored; the upstream source must hold it.
- `IN_DEPTH`=1: FILL→DIV on the first handshake, and DRAIN emits exactly one beat.

## Test plan

- Block `[100,-50,25,0]`, `[200,-200,10,1]` -> `max_num`=200, `recip`=41615; outputs `[63,-32,16,0]` then `[127,-127,6,1]`.
- All-zero block -> `max_num`=0; all outputs 0; `data_out_valid` timing unchanged.
- Block containing -32768 and 32767 -> `max_num`=32767, `recip`=254; quantized -127 and 127 respectively.
- Latency/throughput, ready always high:
  - First `data_out_valid` exactly 25 cycles after the last input handshake.
  - Two output beats on consecutive cycles.
  - `data_in_ready` high the cycle after.
- Hold `data_out_ready` low 5 cycles on the first output beat -> `data_out` and `max_num` stable; `data_in_ready`=0; both beats delivered in order, none lost.
- `rst` low 1 cycle during DIV -> `data_out_valid`=0, `data_in_ready`=1 next cycle; the following block quantizes correctly with no stale max.
